// File: rtl/core_ctrl_seq.sv
// xRV32I pipeline sequencer: owns the PC and drives IF/ID, ID/EX flush/hold controls.
// Control outputs are combinational from state and requests; pc and counters update on the clock edge.
module core_ctrl_seq #(
    parameter logic [31:0] RST_ADDR     = 32'h0000_0000,
    parameter int          FLUSH_CYCLES = 1,
    parameter int          HOLD_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jump_flag_in,
    input  logic [31:0] jump_addr_in,
    input  logic        hold_flag_ex_in,
    input  logic        hold_req_bus_in,
    output logic [31:0] pc_out,
    output logic        inst_valid_out,
    output logic        flush_out,
    output logic        hold_pc_out,
    output logic        hold_pipe_out,
    output logic        jump_misalign_out,
    output logic        hold_timeout_out
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        HOLD  = 2'd3
    } state_t;

    localparam int             HW          = $clog2(HOLD_TIMEOUT + 1);
    localparam logic [HW-1:0]  HOLD_MAX    = HW'(HOLD_TIMEOUT);
    localparam logic [1:0]     FLUSH_LOAD  = 2'(FLUSH_CYCLES - 1);
    localparam bit             MULTI_FLUSH = (FLUSH_CYCLES > 1);

    state_t        state, state_nxt;
    logic [31:0]   pc, pc_nxt;
    logic [1:0]    flush_cnt, flush_cnt_nxt;
    logic [HW-1:0] hold_cnt, hold_cnt_nxt;
    logic          timeout_q;

    logic [31:0] jump_pc;
    logic [31:0] pc_inc;
    logic        any_hold;
    logic        held;

    assign jump_pc  = {jump_addr_in[31:2], 2'b00};
    assign pc_inc   = pc + 32'd4;
    assign any_hold = hold_req_bus_in | hold_flag_ex_in;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= BOOT;
            pc        <= RST_ADDR;
            flush_cnt <= 2'd0;
            hold_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            pc        <= pc_nxt;
            flush_cnt <= flush_cnt_nxt;
            hold_cnt  <= hold_cnt_nxt;
            if (held && (hold_cnt_nxt == HOLD_MAX)) begin
                timeout_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt         = state;
        pc_nxt            = pc;
        flush_cnt_nxt     = flush_cnt;
        inst_valid_out    = 1'b0;
        flush_out         = 1'b0;
        hold_pc_out       = 1'b0;
        hold_pipe_out     = 1'b0;
        jump_misalign_out = 1'b0;

        case (state)
            BOOT: begin
                hold_pc_out = 1'b1;
                state_nxt   = RUN;
            end

            RUN, HOLD, FLUSH: begin
                if (jump_flag_in) begin
                    // A taken jump restarts the bubble sequence from any active state.
                    flush_out         = 1'b1;
                    jump_misalign_out = |jump_addr_in[1:0];
                    pc_nxt            = jump_pc;
                    flush_cnt_nxt     = FLUSH_LOAD;
                    if (MULTI_FLUSH) begin
                        state_nxt = FLUSH;
                    end else if (hold_req_bus_in) begin
                        state_nxt = HOLD;
                    end else begin
                        state_nxt = RUN;
                    end
                end else if (state == FLUSH) begin
                    flush_out = 1'b1;
                    if (hold_req_bus_in) begin
                        hold_pc_out = 1'b1;
                    end else begin
                        pc_nxt        = pc_inc;
                        flush_cnt_nxt = (flush_cnt == 2'd0) ? 2'd0 : flush_cnt - 2'd1;
                        if (flush_cnt <= 2'd1) begin
                            state_nxt = RUN;
                        end
                    end
                end else if (any_hold) begin
                    hold_pc_out   = 1'b1;
                    hold_pipe_out = 1'b1;
                    state_nxt     = HOLD;
                end else if (state == RUN) begin
                    inst_valid_out = 1'b1;
                    pc_nxt         = pc_inc;
                end else begin
                    // Release cycle: the held pc is re-presented by the first RUN cycle.
                    state_nxt = RUN;
                end
            end

            default: begin
                state_nxt = BOOT;
            end
        endcase
    end

    assign held = hold_pc_out && ((state == RUN) || (state == HOLD));

    always_comb begin
        hold_cnt_nxt = '0;
        if (held) begin
            hold_cnt_nxt = (hold_cnt == HOLD_MAX) ? hold_cnt : hold_cnt + 1'b1;
        end
    end

    assign pc_out           = pc;
    assign hold_timeout_out = timeout_q;

endmodule

// File: tb/tb_core_ctrl_seq.sv
// Scenario bench for core_ctrl_seq with FLUSH_CYCLES=2 and HOLD_TIMEOUT=4; expected fetch pcs queue up as stimulus is driven.
module tb_core_ctrl_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        jump_flag_in;
    logic [31:0] jump_addr_in;
    logic        hold_flag_ex_in;
    logic        hold_req_bus_in;
    logic [31:0] pc_out;
    logic        inst_valid_out;
    logic        flush_out;
    logic        hold_pc_out;
    logic        hold_pipe_out;
    logic        jump_misalign_out;
    logic        hold_timeout_out;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    core_ctrl_seq #(
        .RST_ADDR    (32'h0000_0000),
        .FLUSH_CYCLES(2),
        .HOLD_TIMEOUT(4)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .jump_flag_in     (jump_flag_in),
        .jump_addr_in     (jump_addr_in),
        .hold_flag_ex_in  (hold_flag_ex_in),
        .hold_req_bus_in  (hold_req_bus_in),
        .pc_out           (pc_out),
        .inst_valid_out   (inst_valid_out),
        .flush_out        (flush_out),
        .hold_pc_out      (hold_pc_out),
        .hold_pipe_out    (hold_pipe_out),
        .jump_misalign_out(jump_misalign_out),
        .hold_timeout_out (hold_timeout_out)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish within the time limit");
        $fatal(1);
    end

    task automatic drive_cycle(input logic jf, input logic [31:0] ja, input logic hex, input logic hbus);
        @(negedge clk);
        jump_flag_in    = jf;
        jump_addr_in    = ja;
        hold_flag_ex_in = hex;
        hold_req_bus_in = hbus;
        #1;
    endtask

    task automatic do_reset;
        @(negedge clk);
        rst             = 1'b1;
        jump_flag_in    = 1'b0;
        jump_addr_in    = 32'h0;
        hold_flag_ex_in = 1'b0;
        hold_req_bus_in = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset;
        #2;
        checks++; if (pc_out !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h want 00000000", pc_out); end
        checks++; if ({inst_valid_out, flush_out, hold_pipe_out, jump_misalign_out, hold_timeout_out} !== 5'b0) begin
            errors++; $display("FAIL reset_outs: got %b want 00000", {inst_valid_out, flush_out, hold_pipe_out, jump_misalign_out, hold_timeout_out});
        end
        checks++; if (hold_pc_out !== 1'b1) begin errors++; $display("FAIL reset_hold_pc: got %b want 1", hold_pc_out); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if ({pc_out, inst_valid_out, hold_pc_out} !== {32'h0, 1'b0, 1'b1}) begin
            errors++; $display("FAIL boot_cycle: pc=%h valid=%b hold_pc=%b want pc=0 valid=0 hold_pc=1", pc_out, inst_valid_out, hold_pc_out);
        end
    endtask

    task automatic test_boot_run;
        logic [31:0] e;
        for (int i = 0; i < 4; i++) exp_q.push_back(32'(i * 4));
        for (int i = 0; i < 4; i++) begin
            drive_cycle(1'b0, 32'h0, 1'b0, 1'b0);
            checks++;
            if (inst_valid_out !== 1'b1) begin errors++; $display("FAIL run_valid[%0d]: got %b want 1", i, inst_valid_out); end
            else begin
                e = exp_q.pop_front();
                if (pc_out !== e) begin errors++; $display("FAIL run_pc[%0d]: got %h want %h", i, pc_out, e); end
            end
        end
    endtask

    task automatic test_jump;
        logic [31:0] e;
        int flush_seen = 0;
        drive_cycle(1'b1, 32'h0000_0100, 1'b0, 1'b0);
        flush_seen += int'(flush_out);
        checks++; if ({pc_out, inst_valid_out, jump_misalign_out} !== {32'h10, 1'b0, 1'b0}) begin
            errors++; $display("FAIL jump_cycle: pc=%h valid=%b misalign=%b want pc=10 valid=0 misalign=0", pc_out, inst_valid_out, jump_misalign_out);
        end
        drive_cycle(1'b0, 32'h0, 1'b0, 1'b0);
        flush_seen += int'(flush_out);
        checks++; if ({pc_out, inst_valid_out} !== {32'h100, 1'b0}) begin
            errors++; $display("FAIL jump_bubble: pc=%h valid=%b want pc=100 valid=0", pc_out, inst_valid_out);
        end
        exp_q.push_back(32'h104);
        drive_cycle(1'b0, 32'h0, 1'b0, 1'b0);
        flush_seen += int'(flush_out);
        checks++;
        if (inst_valid_out !== 1'b1) begin errors++; $display("FAIL jump_resume_valid: got %b want 1", inst_valid_out); end
        else begin
            e = exp_q.pop_front();
            if (pc_out !== e) begin errors++; $display("FAIL jump_resume_pc: got %h want %h", pc_out, e); end
        end
        checks++; if (flush_seen != 2) begin errors++; $display("FAIL jump_flush_len: got %0d want 2", flush_seen); end
    endtask

    task automatic test_hold_ex;
        logic [31:0] e;
        int hold_seen = 0;
        do_reset();
        for (int i = 0; i < 8; i++) exp_q.push_back(32'(i * 4));
        for (int i = 0; i < 8; i++) begin
            drive_cycle(1'b0, 32'h0, 1'b0, 1'b0);
            checks++;
            if (inst_valid_out !== 1'b1) begin errors++; $display("FAIL pre_hold_valid[%0d]: got %b want 1", i, inst_valid_out); end
            else begin
                e = exp_q.pop_front();
                if (pc_out !== e) begin errors++; $display("FAIL pre_hold_pc[%0d]: got %h want %h", i, pc_out, e); end
            end
        end
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b0, 32'h0, 1'b1, 1'b0);
            hold_seen += int'(hold_pc_out && hold_pipe_out);
            checks++; if ({pc_out, inst_valid_out, flush_out} !== {32'h20, 1'b0, 1'b0}) begin
                errors++; $display("FAIL hold_ex[%0d]: pc=%h valid=%b flush=%b want pc=20 valid=0 flush=0", i, pc_out, inst_valid_out, flush_out);
            end
        end
        drive_cycle(1'b0, 32'h0, 1'b0, 1'b0);
        hold_seen += int'(hold_pc_out && hold_pipe_out);
        checks++; if ({pc_out, inst_valid_out} !== {32'h20, 1'b0}) begin
            errors++; $display("FAIL hold_release: pc=%h valid=%b want pc=20 valid=0", pc_out, inst_valid_out);
        end
        exp_q.push_back(32'h20);
        exp_q.push_back(32'h24);
        for (int i = 0; i < 2; i++) begin
            drive_cycle(1'b0, 32'h0, 1'b0, 1'b0);
            hold_seen += int'(hold_pc_out && hold_pipe_out);
            checks++;
            if (inst_valid_out !== 1'b1) begin errors++; $display("FAIL post_hold_valid[%0d]: got %b want 1", i, inst_valid_out); end
            else begin
                e = exp_q.pop_front();
                if (pc_out !== e) begin errors++; $display("FAIL post_hold_pc[%0d]: got %h want %h", i, pc_out, e); end
            end
        end
        checks++; if (hold_seen != 3) begin errors++; $display("FAIL hold_len: got %0d want 3", hold_seen); end
    endtask

    task automatic test_jump_bus_misalign;
        logic [31:0] e;
        drive_cycle(1'b1, 32'h0000_0202, 1'b0, 1'b1);
        checks++; if ({jump_misalign_out, flush_out, hold_pipe_out, inst_valid_out} !== 4'b1100) begin
            errors++; $display("FAIL misalign_cycle: mis/flush/pipe/valid=%b want 1100", {jump_misalign_out, flush_out, hold_pipe_out, inst_valid_out});
        end
        for (int i = 0; i < 2; i++) begin
            drive_cycle(1'b0, 32'h0, 1'b0, 1'b1);
            checks++; if ({pc_out, flush_out, hold_pipe_out, jump_misalign_out} !== {32'h200, 3'b100}) begin
                errors++; $display("FAIL bus_frozen[%0d]: pc=%h flush=%b pipe=%b mis=%b want pc=200 flush=1 pipe=0 mis=0", i, pc_out, flush_out, hold_pipe_out, jump_misalign_out);
            end
        end
        drive_cycle(1'b0, 32'h0, 1'b0, 1'b0);
        checks++; if ({pc_out, flush_out, inst_valid_out} !== {32'h200, 2'b10}) begin
            errors++; $display("FAIL bus_release_bubble: pc=%h flush=%b valid=%b want pc=200 flush=1 valid=0", pc_out, flush_out, inst_valid_out);
        end
        exp_q.push_back(32'h204);
        drive_cycle(1'b0, 32'h0, 1'b0, 1'b0);
        checks++;
        if ({inst_valid_out, flush_out} !== 2'b10) begin errors++; $display("FAIL bus_resume: valid/flush=%b want 10", {inst_valid_out, flush_out}); end
        else begin
            e = exp_q.pop_front();
            if (pc_out !== e) begin errors++; $display("FAIL bus_resume_pc: got %h want %h", pc_out, e); end
        end
    endtask

    task automatic test_hold_jump_priority;
        logic [31:0] e;
        drive_cycle(1'b0, 32'h0, 1'b1, 1'b0);
        checks++; if ({pc_out, hold_pipe_out} !== {32'h208, 1'b1}) begin
            errors++; $display("FAIL prio_enter_hold: pc=%h pipe=%b want pc=208 pipe=1", pc_out, hold_pipe_out);
        end
        drive_cycle(1'b1, 32'h0000_0300, 1'b1, 1'b0);
        checks++; if ({flush_out, hold_pipe_out, hold_pc_out, inst_valid_out} !== 4'b1000) begin
            errors++; $display("FAIL prio_jump_in_hold: flush/pipe/hold_pc/valid=%b want 1000", {flush_out, hold_pipe_out, hold_pc_out, inst_valid_out});
        end
        drive_cycle(1'b0, 32'h0, 1'b1, 1'b0);
        checks++; if ({pc_out, flush_out, hold_pipe_out} !== {32'h300, 2'b10}) begin
            errors++; $display("FAIL prio_flush_ignores_ex: pc=%h flush=%b pipe=%b want pc=300 flush=1 pipe=0", pc_out, flush_out, hold_pipe_out);
        end
        exp_q.push_back(32'h304);
        drive_cycle(1'b0, 32'h0, 1'b0, 1'b0);
        checks++;
        if (inst_valid_out !== 1'b1) begin errors++; $display("FAIL prio_resume_valid: got %b want 1", inst_valid_out); end
        else begin
            e = exp_q.pop_front();
            if (pc_out !== e) begin errors++; $display("FAIL prio_resume_pc: got %h want %h", pc_out, e); end
        end
    endtask

    task automatic test_wrap;
        logic [31:0] e;
        drive_cycle(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);
        checks++; if (jump_misalign_out !== 1'b1) begin errors++; $display("FAIL wrap_misalign: got %b want 1", jump_misalign_out); end
        drive_cycle(1'b0, 32'h0, 1'b0, 1'b0);
        checks++; if (pc_out !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_target: got %h want fffffffc", pc_out); end
        exp_q.push_back(32'h0);
        drive_cycle(1'b0, 32'h0, 1'b0, 1'b0);
        checks++;
        if (inst_valid_out !== 1'b1) begin errors++; $display("FAIL wrap_valid: got %b want 1", inst_valid_out); end
        else begin
            e = exp_q.pop_front();
            if (pc_out !== e) begin errors++; $display("FAIL wrap_pc: got %h want %h", pc_out, e); end
        end
    endtask

    task automatic test_watchdog;
        logic [31:0] e;
        do_reset();
        exp_q.push_back(32'h0);
        drive_cycle(1'b0, 32'h0, 1'b0, 1'b0);
        checks++;
        if (inst_valid_out !== 1'b1) begin errors++; $display("FAIL wd_first_valid: got %b want 1", inst_valid_out); end
        else begin
            e = exp_q.pop_front();
            if (pc_out !== e) begin errors++; $display("FAIL wd_first_pc: got %h want %h", pc_out, e); end
        end
        for (int k = 1; k <= 6; k++) begin
            drive_cycle(1'b0, 32'h0, 1'b0, 1'b1);
            checks++; if ({pc_out, hold_pc_out, hold_timeout_out} !== {32'h4, 1'b1, (k >= 5)}) begin
                errors++; $display("FAIL wd_held[%0d]: pc=%h hold_pc=%b timeout=%b want pc=4 hold_pc=1 timeout=%b", k, pc_out, hold_pc_out, hold_timeout_out, (k >= 5));
            end
        end
        drive_cycle(1'b0, 32'h0, 1'b0, 1'b0);
        exp_q.push_back(32'h4);
        drive_cycle(1'b0, 32'h0, 1'b0, 1'b0);
        checks++;
        if ({inst_valid_out, hold_timeout_out} !== 2'b11) begin errors++; $display("FAIL wd_sticky: valid/timeout=%b want 11", {inst_valid_out, hold_timeout_out}); end
        else begin
            e = exp_q.pop_front();
            if (pc_out !== e) begin errors++; $display("FAIL wd_resume_pc: got %h want %h", pc_out, e); end
        end
        do_reset();
        checks++; if (hold_timeout_out !== 1'b0) begin errors++; $display("FAIL wd_cleared_by_rst: got %b want 0", hold_timeout_out); end
    endtask

    task automatic test_async_reset;
        logic [31:0] e;
        do_reset();
        drive_cycle(1'b0, 32'h0, 1'b0, 1'b0);
        drive_cycle(1'b1, 32'h0000_0040, 1'b0, 1'b0);
        drive_cycle(1'b0, 32'h0, 1'b0, 1'b0);
        checks++; if ({pc_out, flush_out} !== {32'h40, 1'b1}) begin
            errors++; $display("FAIL async_pre: pc=%h flush=%b want pc=40 flush=1", pc_out, flush_out);
        end
        #2 rst = 1'b1;
        #1;
        checks++; if ({pc_out, flush_out, inst_valid_out, hold_pc_out} !== {32'h0, 3'b001}) begin
            errors++; $display("FAIL async_rst: pc=%h flush=%b valid=%b hold_pc=%b want pc=0 flush=0 valid=0 hold_pc=1", pc_out, flush_out, inst_valid_out, hold_pc_out);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if ({pc_out, inst_valid_out, hold_pc_out} !== {32'h0, 2'b01}) begin
            errors++; $display("FAIL async_boot: pc=%h valid=%b hold_pc=%b want pc=0 valid=0 hold_pc=1", pc_out, inst_valid_out, hold_pc_out);
        end
        exp_q.push_back(32'h0);
        drive_cycle(1'b0, 32'h0, 1'b0, 1'b0);
        checks++;
        if (inst_valid_out !== 1'b1) begin errors++; $display("FAIL async_run_valid: got %b want 1", inst_valid_out); end
        else begin
            e = exp_q.pop_front();
            if (pc_out !== e) begin errors++; $display("FAIL async_run_pc: got %h want %h", pc_out, e); end
        end
    endtask

    initial begin
        rst             = 1'b1;
        jump_flag_in    = 1'b0;
        jump_addr_in    = 32'h0;
        hold_flag_ex_in = 1'b0;
        hold_req_bus_in = 1'b0;
        test_reset();
        test_boot_run();
        test_jump();
        test_hold_ex();
        test_jump_bus_misalign();
        test_hold_jump_priority();
        test_wrap();
        test_watchdog();
        test_async_reset();
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain: %0d entries left want 0", exp_q.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
